// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of independent programmable clock dividers, all on one clock.
// Each channel produces a registered divided clock, a one-cycle tick on every rising
// edge of that clock, and status flags. Divisor changes and enable changes take
// effect only where a period starts or ends, so no output ever shows a runt pulse.
// sync_restart is the only path that can cut a high phase short.
module clk_div_bank #(
  parameter int                      NUM_CH   = 4,
  parameter int                      DIV_W    = 8,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd24, 8'd16, 8'd2, 8'd4}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    sync_restart,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending,
  output logic [NUM_CH-1:0]       running
);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  // Divisors 0 and 1 cannot form a clock, so they behave as divide-by-2.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < TWO) ? TWO : d;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state;
    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] cnt;
    logic             clk_r;
    logic             tick_r;
    logic             pend_r;

    logic [DIV_W-1:0] load_val;
    logic [DIV_W-1:0] next_div;
    logic [DIV_W-1:0] n_eff;
    logic [DIV_W-1:0] h_eff;
    logic [DIV_W-1:0] cnt_inc;
    logic             has_new;
    logic             at_bnd;
    logic             take;

    // Period bookkeeping; a same-cycle load overrides the shadow so it can be applied at once.
    always_comb begin
      load_val = div_val[g*DIV_W +: DIV_W];
      next_div = div_load[g] ? load_val : shadow;
      has_new  = div_load[g] | pend_r;
      n_eff    = eff_div(div_cur);
      h_eff    = n_eff >> 1;
      cnt_inc  = cnt + ONE;
      at_bnd   = (state == ST_RUN) && (cnt == (n_eff - ONE));
      // Edges where a period may start or stop: restart, idle, or end of period.
      take     = sync_restart | (state == ST_STOP) | at_bnd;
    end

    // Channel state, divisor shadowing and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= ST_STOP;
        div_cur <= DIV_INIT[g*DIV_W +: DIV_W];
        shadow  <= DIV_INIT[g*DIV_W +: DIV_W];
        cnt     <= DIV_INIT[g*DIV_W +: DIV_W] - ONE;
        clk_r   <= 1'b0;
        tick_r  <= 1'b0;
        pend_r  <= 1'b0;
      end else begin
        if (div_load[g]) shadow <= load_val;

        if (take && has_new) begin
          div_cur <= next_div;
          pend_r  <= 1'b0;
        end else if (div_load[g]) begin
          pend_r  <= 1'b1;
        end

        if (take) begin
          if (en[g]) begin
            state  <= ST_RUN;
            cnt    <= '0;
            clk_r  <= 1'b1;
            tick_r <= 1'b1;
          end else begin
            // cnt holds so a stopped channel sits at its period end.
            state  <= ST_STOP;
            clk_r  <= 1'b0;
            tick_r <= 1'b0;
          end
        end else begin
          cnt    <= cnt_inc;
          clk_r  <= (cnt_inc < h_eff);
          tick_r <= 1'b0;
        end
      end
    end

    assign clk_out[g] = clk_r;
    assign tick[g]    = tick_r;
    assign pending[g] = pend_r;
    assign running[g] = (state == ST_RUN);
  end

endmodule
